// File: rtl/riot_pkg.sv
// Shared types and constants for the RIOT-style multi-channel interval timer bank.
package riot_pkg;

    typedef enum logic [1:0] {
        DIV1    = 2'd0,
        DIV8    = 2'd1,
        DIV64   = 2'd2,
        DIV1024 = 2'd3
    } div_sel_t;

    localparam int unsigned PRESCALE_W = 10;

    localparam logic [PRESCALE_W-1:0] PRESCALE_MAX_1    = 10'd0;
    localparam logic [PRESCALE_W-1:0] PRESCALE_MAX_8    = 10'd7;
    localparam logic [PRESCALE_W-1:0] PRESCALE_MAX_64   = 10'd63;
    localparam logic [PRESCALE_W-1:0] PRESCALE_MAX_1024 = 10'd1023;

    // Address offset bits: control fields on write, read select on read
    localparam int unsigned OFF_AUTO   = 3;
    localparam int unsigned OFF_IRQ    = 2;
    localparam int unsigned OFF_DIV_HI = 1;
    localparam int unsigned OFF_DIV_LO = 0;
    localparam int unsigned OFF_STATUS = 0;

    // Status byte layout
    localparam int unsigned ST_FLAG   = 7;
    localparam int unsigned ST_IRQ_EN = 6;
    localparam int unsigned ST_MODE   = 5;
    localparam int unsigned ST_DIV_HI = 4;
    localparam int unsigned ST_DIV_LO = 3;
    localparam int unsigned ST_RUN    = 2;

    function automatic logic [PRESCALE_W-1:0] prescale_max(input div_sel_t d);
        case (d)
            DIV8:    return PRESCALE_MAX_8;
            DIV64:   return PRESCALE_MAX_64;
            DIV1024: return PRESCALE_MAX_1024;
            default: return PRESCALE_MAX_1;
        endcase
    endfunction

endpackage

// File: rtl/riot_timer_bank_if.sv
// phi2 bus seen by the timer bank: select, direction, address, write data and read return.
interface riot_timer_bank_if #(
    parameter int unsigned NUM_TIMERS = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ADDR_W     = $clog2(NUM_TIMERS) + 4
);
    logic              enable;
    logic              we_n;
    logic [ADDR_W-1:0] A;
    logic [CNT_W-1:0]  DI;
    logic [CNT_W-1:0]  DO;
    logic              OE;

    modport master (output enable, we_n, A, DI, input  DO, OE);
    modport slave  (input  enable, we_n, A, DI, output DO, OE);
endinterface

// File: rtl/timer_channel.sv
// One prescaled down-counter channel: halted until first written, one-shot or auto-reload.
module timer_channel
    import riot_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic             i_rd_cnt,
    input  logic [3:0]       i_ctl,
    input  logic [CNT_W-1:0] i_di,
    output logic [CNT_W-1:0] o_count,
    output logic             o_flag,
    output logic             o_irq_en,
    output logic [7:0]       o_status
);

    logic [PRESCALE_W-1:0] r_pre;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_reload;
    div_sel_t              r_div;
    logic                  r_auto;
    logic                  r_flag;
    logic                  r_irq_en;
    logic                  r_run;
    logic                  w_tick;
    logic                  w_timeout;

    assign w_tick    = r_run && (r_pre == prescale_max(r_div));
    assign w_timeout = w_tick && (r_count == '0);

    // Write beats everything; timeout flag set beats a count-read clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre    <= '0;
            r_count  <= '0;
            r_reload <= '0;
            r_div    <= DIV1;
            r_auto   <= 1'b0;
            r_flag   <= 1'b0;
            r_irq_en <= 1'b0;
            r_run    <= 1'b0;
        end else if (i_wr) begin
            r_pre    <= '0;
            r_count  <= i_di;
            r_reload <= i_di;
            r_div    <= div_sel_t'(i_ctl[OFF_DIV_HI:OFF_DIV_LO]);
            r_auto   <= i_ctl[OFF_AUTO];
            r_irq_en <= i_ctl[OFF_IRQ];
            r_flag   <= 1'b0;
            r_run    <= 1'b1;
        end else begin
            if (r_run) begin
                r_pre <= w_tick ? '0 : r_pre + PRESCALE_W'(1);
            end
            if (w_tick) begin
                if (r_count != '0) begin
                    r_count <= r_count - CNT_W'(1);
                end else if (r_auto) begin
                    r_count <= r_reload;
                end else begin
                    r_count <= '1;
                    r_div   <= DIV1;
                end
            end
            if (w_timeout) begin
                r_flag <= 1'b1;
            end else if (i_rd_cnt) begin
                r_flag <= 1'b0;
            end
            if (i_rd_cnt) begin
                r_irq_en <= i_ctl[OFF_IRQ];
            end
        end
    end

    always_comb begin
        o_status                      = '0;
        o_status[ST_FLAG]             = r_flag;
        o_status[ST_IRQ_EN]           = r_irq_en;
        o_status[ST_MODE]             = r_auto;
        o_status[ST_DIV_HI:ST_DIV_LO] = r_div;
        o_status[ST_RUN]              = r_run;
    end

    assign o_count  = r_count;
    assign o_flag   = r_flag;
    assign o_irq_en = r_irq_en;

endmodule

// File: rtl/riot_timer_bank.sv
// N-channel RIOT interval timer bank: address decode, registered read mux and irq OR-reduce.
module riot_timer_bank
    import riot_pkg::*;
#(
    parameter int unsigned NUM_TIMERS = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ADDR_W     = $clog2(NUM_TIMERS) + 4
) (
    input  logic                  phi2,
    input  logic                  rst,
    riot_timer_bank_if.slave      bus,
    output logic                  irq,
    output logic [NUM_TIMERS-1:0] irq_en
);

    // Channel field padded to at least one bit; unpopulated slots read as zero
    localparam int unsigned CHW   = (ADDR_W > 4) ? ADDR_W - 4 : 1;
    localparam int unsigned NSLOT = 1 << CHW;

    logic                  w_wr;
    logic                  w_rd;
    logic [CHW-1:0]        w_chan;
    logic [3:0]            w_off;
    logic [CNT_W-1:0]      w_count  [NSLOT];
    logic [7:0]            w_status [NSLOT];
    logic [NUM_TIMERS-1:0] w_flag;
    logic [CNT_W-1:0]      r_do;
    logic                  r_oe;

    assign w_wr   = bus.enable & ~bus.we_n;
    assign w_rd   = bus.enable &  bus.we_n;
    assign w_chan = CHW'(bus.A >> 4);
    assign w_off  = bus.A[3:0];

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < NUM_TIMERS) begin : g_pop
            timer_channel #(.CNT_W(CNT_W)) u_ch (
                .clk      (phi2),
                .rst      (rst),
                .i_wr     (w_wr && (w_chan == CHW'(g))),
                .i_rd_cnt (w_rd && (w_chan == CHW'(g)) && !w_off[OFF_STATUS]),
                .i_ctl    (w_off),
                .i_di     (bus.DI),
                .o_count  (w_count[g]),
                .o_flag   (w_flag[g]),
                .o_irq_en (irq_en[g]),
                .o_status (w_status[g])
            );
        end else begin : g_empty
            assign w_count[g]  = '0;
            assign w_status[g] = '0;
        end
    end

    // Read data captured at the request edge, valid for exactly the following cycle
    always_ff @(posedge phi2) begin
        if (rst) begin
            r_do <= '0;
            r_oe <= 1'b0;
        end else begin
            r_oe <= w_rd;
            if (!w_rd) begin
                r_do <= '0;
            end else if (w_off[OFF_STATUS]) begin
                r_do <= CNT_W'(w_status[w_chan]);
            end else begin
                r_do <= w_count[w_chan];
            end
        end
    end

    assign bus.DO = r_do;
    assign bus.OE = r_oe;
    assign irq    = |(w_flag & irq_en);

endmodule

// File: tb/tb_riot_timer_bank.sv
// Scoreboard bench for riot_timer_bank: read results queued at request time, checked on OE.
module tb_riot_timer_bank;

    localparam int unsigned NT = 3;
    localparam int unsigned CW = 8;
    localparam int unsigned AW = $clog2(NT) + 4;

    logic          phi2 = 1'b0;
    logic          rst  = 1'b1;
    logic          irq;
    logic [NT-1:0] irq_en;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CW-1:0] exp_q[$];

    riot_timer_bank_if #(.NUM_TIMERS(NT), .CNT_W(CW)) bus ();

    riot_timer_bank #(.NUM_TIMERS(NT), .CNT_W(CW)) dut (
        .phi2   (phi2),
        .rst    (rst),
        .bus    (bus),
        .irq    (irq),
        .irq_en (irq_en)
    );

    always #5 phi2 = ~phi2;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] addr(input int ch, input int off);
        return AW'((ch << 4) | off);
    endfunction

    task automatic bus_write(input int ch, input int off, input logic [CW-1:0] d);
        bus.enable = 1'b1; bus.we_n = 1'b0; bus.A = addr(ch, off); bus.DI = d;
        @(posedge phi2); #1;
        bus.enable = 1'b0; bus.we_n = 1'b1;
    endtask

    task automatic bus_read(input int ch, input int off);
        bus.enable = 1'b1; bus.we_n = 1'b1; bus.A = addr(ch, off);
        @(posedge phi2); #1;
        bus.enable = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.enable = 1'b0;
        repeat (n) begin @(posedge phi2); #1; end
    endtask

    task automatic test_reset();
        logic [CW-1:0] e;
        bus.enable = 1'b0; bus.we_n = 1'b1; bus.A = '0; bus.DI = '0;
        rst = 1'b1;
        repeat (3) @(posedge phi2);
        #1;
        n_tests++;
        if (bus.DO !== 8'h00 || bus.OE !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus: DO=%h OE=%b expected DO=00 OE=0", bus.DO, bus.OE);
        end
        n_tests++;
        if (irq !== 1'b0 || irq_en !== 3'b000) begin
            n_fail++; $display("FAIL reset_irq: irq=%b irq_en=%b expected 0/000", irq, irq_en);
        end
        rst = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            exp_q.push_back(8'h00);
            bus_read(ch, 1);
            e = exp_q.pop_front();
            n_tests++;
            if (bus.OE !== 1'b1 || bus.DO !== e) begin
                n_fail++; $display("FAIL reset_status ch%0d: DO=%h OE=%b expected DO=%h OE=1", ch, bus.DO, bus.OE, e);
            end
        end
    endtask

    // /1 one-shot from 3: successive count reads, timeout, wrap to FF and keep running
    task automatic test_oneshot();
        logic [CW-1:0] e;
        bus_write(0, 0, 8'd3);
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: exp_q.push_back(8'h03);
                1: exp_q.push_back(8'h02);
                2: exp_q.push_back(8'h01);
                3: exp_q.push_back(8'h00);
                4: exp_q.push_back(8'h84);
                5: exp_q.push_back(8'hFE);
                default: exp_q.push_back(8'hFD);
            endcase
            bus_read(0, (i == 4) ? 1 : 0);
            e = exp_q.pop_front();
            n_tests++;
            if (bus.OE !== 1'b1 || bus.DO !== e) begin
                n_fail++; $display("FAIL oneshot step%0d: DO=%h OE=%b expected DO=%h OE=1", i, bus.DO, bus.OE, e);
            end
        end
        n_tests++;
        if (irq !== 1'b0 || irq_en !== 3'b000) begin
            n_fail++; $display("FAIL oneshot_irq: irq=%b irq_en=%b expected 0/000", irq, irq_en);
        end
    endtask

    // /64 with irq enabled: irq edge 192 cycles after the write edge
    task automatic test_irq_prescale();
        logic [CW-1:0] e;
        int k;
        bus_write(1, 6, 8'd2);
        k = 0;
        while (irq !== 1'b1 && k < 300) begin
            @(posedge phi2); #1; k++;
        end
        n_tests++;
        if (k != 192) begin
            n_fail++; $display("FAIL irq_latency: irq after %0d cycles expected 192", k);
        end
        n_tests++;
        if (irq_en !== 3'b010) begin
            n_fail++; $display("FAIL irq_en_vec: irq_en=%b expected 010", irq_en);
        end
        exp_q.push_back(8'hFF);
        bus_read(1, 4);
        e = exp_q.pop_front();
        n_tests++;
        if (bus.OE !== 1'b1 || bus.DO !== e) begin
            n_fail++; $display("FAIL irq_clear_read: DO=%h OE=%b expected DO=%h OE=1", bus.DO, bus.OE, e);
        end
        n_tests++;
        if (irq !== 1'b0 || irq_en !== 3'b010) begin
            n_fail++; $display("FAIL irq_cleared: irq=%b irq_en=%b expected 0/010", irq, irq_en);
        end
    endtask

    // /8 auto-reload from 4: flag every 40 cycles, reload value and divider kept
    task automatic test_autoreload();
        logic [CW-1:0] e;
        int c;
        int first;
        int second;
        logic [CW-1:0] last_st;
        bus_write(0, 9, 8'd4);
        c = 0; first = 0; second = 0; last_st = '0;
        while (c < 100 && first == 0) begin
            bus_read(0, 1); c++;
            if (bus.DO[7] === 1'b1) first = c;
        end
        n_tests++;
        if (first != 41) begin
            n_fail++; $display("FAIL autoreload_first: flag seen at read %0d expected 41", first);
        end
        exp_q.push_back(8'h04);
        bus_read(0, 0); c++;
        e = exp_q.pop_front();
        n_tests++;
        if (bus.OE !== 1'b1 || bus.DO !== e) begin
            n_fail++; $display("FAIL autoreload_reload: DO=%h expected %h", bus.DO, e);
        end
        while (c < 200 && second == 0) begin
            bus_read(0, 1); c++;
            last_st = bus.DO;
            if (bus.DO[7] === 1'b1) second = c;
        end
        n_tests++;
        if (second != 81) begin
            n_fail++; $display("FAIL autoreload_period: flag seen at read %0d expected 81", second);
        end
        n_tests++;
        if (last_st !== 8'hAC) begin
            n_fail++; $display("FAIL autoreload_status: DO=%h expected AC", last_st);
        end
    endtask

    // Status read leaves the flag; a later count read clears it
    task automatic test_status_keep();
        logic [CW-1:0] e;
        int k;
        bus_read(1, 4);
        k = 0;
        while (irq !== 1'b1 && k < 300) begin
            @(posedge phi2); #1; k++;
        end
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL status_wait: irq=%b after %0d cycles expected 1", irq, k);
        end
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1:    exp_q.push_back(8'hC4);
                2:       exp_q.push_back(8'hFD);
                default: exp_q.push_back(8'h44);
            endcase
            bus_read(1, (i == 2) ? 4 : 1);
            e = exp_q.pop_front();
            n_tests++;
            if (bus.OE !== 1'b1 || bus.DO !== e || irq !== (i < 2)) begin
                n_fail++; $display("FAIL status_keep step%0d: DO=%h irq=%b expected DO=%h irq=%b", i, bus.DO, irq, e, (i < 2));
            end
        end
    endtask

    // Count read and write each landing on the timeout edge
    task automatic test_simultaneous();
        logic [CW-1:0] e;
        bus_write(0, 0, 8'd2);
        idle(2);
        exp_q.push_back(8'h00);
        bus_read(0, 0);
        exp_q.push_back(8'h84);
        bus_read(0, 1);
        e = exp_q.pop_front();
        n_tests++;
        if (e !== 8'h00) begin
            n_fail++; $display("FAIL simul_queue: order error");
        end
        e = exp_q.pop_front();
        n_tests++;
        if (bus.OE !== 1'b1 || bus.DO !== e) begin
            n_fail++; $display("FAIL simul_read_flag: DO=%h expected %h", bus.DO, e);
        end
        bus_write(0, 0, 8'd2);
        idle(2);
        bus_write(0, 0, 8'h55);
        exp_q.push_back(8'h04);
        bus_read(0, 1);
        e = exp_q.pop_front();
        n_tests++;
        if (bus.OE !== 1'b1 || bus.DO !== e) begin
            n_fail++; $display("FAIL simul_write_flag: DO=%h expected %h", bus.DO, e);
        end
        exp_q.push_back(8'h54);
        bus_read(0, 0);
        e = exp_q.pop_front();
        n_tests++;
        if (bus.OE !== 1'b1 || bus.DO !== e) begin
            n_fail++; $display("FAIL simul_write_count: DO=%h expected %h", bus.DO, e);
        end
    endtask

    // Reset mid-count with irq high, then halted channels and the unpopulated slot
    task automatic test_reset_midcount();
        logic [CW-1:0] e;
        int k;
        int bad;
        bus_write(1, 4, 8'd3);
        k = 0;
        while (irq !== 1'b1 && k < 20) begin
            @(posedge phi2); #1; k++;
        end
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_irq_up: irq=%b expected 1", irq);
        end
        rst = 1'b1;
        bus.enable = 1'b1; bus.we_n = 1'b1; bus.A = addr(0, 0);
        @(posedge phi2); #1;
        rst = 1'b0; bus.enable = 1'b0;
        n_tests++;
        if (irq !== 1'b0 || bus.OE !== 1'b0 || bus.DO !== 8'h00 || irq_en !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_drop: irq=%b OE=%b DO=%h irq_en=%b expected 0/0/00/000", irq, bus.OE, bus.DO, irq_en);
        end
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            exp_q.push_back(8'h00);
            bus_read(i % 2, (i % 500 == 499) ? 0 : 1);
            e = exp_q.pop_front();
            n_tests++;
            if (bus.OE !== 1'b1 || bus.DO !== e || irq !== 1'b0) begin
                n_fail++; bad++;
                if (bad < 5) $display("FAIL rstmid_halted cyc%0d: DO=%h OE=%b irq=%b expected DO=%h OE=1 irq=0", i, bus.DO, bus.OE, irq, e);
            end
        end
        bus_write(0, 0, 8'h20);
        bus_write(3, 0, 8'h77);
        exp_q.push_back(8'h04);
        bus_read(0, 1);
        e = exp_q.pop_front();
        n_tests++;
        if (bus.OE !== 1'b1 || bus.DO !== e) begin
            n_fail++; $display("FAIL unpop_pre: DO=%h expected %h", bus.DO, e);
        end
        for (int off = 0; off < 2; off++) begin
            exp_q.push_back(8'h00);
            bus_read(3, off);
            e = exp_q.pop_front();
            n_tests++;
            if (bus.OE !== 1'b1 || bus.DO !== e) begin
                n_fail++; $display("FAIL unpop_read off%0d: DO=%h OE=%b expected DO=%h OE=1", off, bus.DO, bus.OE, e);
            end
        end
        idle(1);
        n_tests++;
        if (bus.OE !== 1'b0 || bus.DO !== 8'h00) begin
            n_fail++; $display("FAIL oe_after_idle: DO=%h OE=%b expected 00/0", bus.DO, bus.OE);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_irq_prescale();
        test_autoreload();
        test_status_keep();
        test_simultaneous();
        test_reset_midcount();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
